uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin scheduler that shares one `uart_tx` serializer between `N_REQ` byte requesters. It accepts bytes over per-requester valid/ready handshakes, locks the serializer to one requester until that requester's `last` byte, drives `uart_tx`'s `init_i`/`data_i`, and watches its `done_o`. It can insert a programmable idle gap between consecutive bytes. It sits between the on-chip message sources and the single UART TX line.

## Interface
- `N_REQ`, 4: number of requesters (≥2).
- `GAP_W`, 16: width of the inter-byte gap counter.
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  permits new grants; does not abort a byte in flight.
- `gap_i`  in  GAP_W  idle clock cycles inserted after each byte; sampled when `tx_done_i` rises.
- `req_valid_i`  in  N_REQ  per-requester byte valid.
- `req_data_i`  in  N_REQ*8  byte of requester k at `[8k+7:8k]`.
- `req_last_i`  in  N_REQ  byte is the last of a burst; releases the lock.
- `req_ready_o`  out  N_REQ  one-hot accept strobe.
- `grant_o`  out  N_REQ  one-hot current owner; 0 when unlocked and idle.
- `tx_init_o`  out  1  start pulse to `uart_tx.init_i`.
- `tx_data_o`  out  8  byte to `uart_tx.data_i`.
- `tx_done_i`  in  1  from `uart_tx.done_o`.
- `busy_o`  out  1  high in every state other than IDLE, or while the lock is held.

## Operation
- **States** (`sched_state_t`): IDLE, ISSUE, BUSY, GAP.
- **IDLE**
  - Eligible set: only the owner when the lock is held, otherwise every requester with `req_valid_i` high.
  - If `enable_i`, `tx_done_i` and the eligible set is non-empty:
    - pick the winner round-robin, starting at the requester after the last winner;
    - assert `req_ready_o[w]` combinationally in the same cycle;
    - register the byte into `tx_data_o`;
    - set lock = `!req_last_i[w]` and owner = w;
    - advance the RR pointer to w;
    - go to ISSUE.
- **ISSUE**: `tx_init_o` = 1 for exactly this one cycle, then go to BUSY.
- **BUSY**: wait for `tx_done_i` = 1.
  - Then go to GAP, loading the counter with `gap_i`.
  - If `gap_i` = 0, go straight to IDLE.
- **GAP**: decrement the counter each cycle; at 1, go to IDLE.
- **Data hold**: `tx_data_o` holds from ISSUE until the next accept, because the serializer samples data at the end of its start bit.
- **Lock held, owner's valid low**: the scheduler waits indefinitely. There is no timeout and other requesters are not served.
- **`enable_i` low**:
  - The in-flight byte and the gap complete normally.
  - The lock is retained, and the burst resumes when `enable_i` returns.
- **`grant_o`** = onehot(owner) while locked or in ISSUE/BUSY/GAP, else 0.
- **Reset values**: all outputs 0. State is IDLE, lock is 0, and the RR pointer makes requester 0 highest priority first.
- **Reset mid-operation**: the scheduler aborts immediately. `uart_tx` shares `rst_n_i`, so both restart clean.

## Timing
- Accept at cycle c → `tx_init_o` in cycle c+1 → `tx_done_i` low from c+2.
- Earliest next accept: the cycle after BUSY sees `tx_done_i` high (gap 0), or `gap_i` cycles later.
- The `tx_init_o` pulse is never wider than 1 cycle. A wider pulse would start a second frame.
- **Simultaneous valids**: exactly one `req_ready_o` bit is high, and never in any state except IDLE.
- **RR wrap**: after winner N_REQ-1, the search starts at 0.
- **Last byte**: a single-byte burst (last=1 on the first byte) never sets the lock.

## Structure
- `uart_pkg`: `sched_state_t` enum (2 bits).
- Sub-module `rr_arbiter`, parameter N:
  - inputs: request vector, pointer;
  - output: one-hot winner;
  - purely combinational double-vector priority pick.
- The scheduler owns the FSM, lock/owner, RR pointer, data register and gap counter.

## Test plan
- **Single byte**: req 2 sends 0xA5 with last=1 and gap 0. Expect `req_ready_o` = 0100, `tx_init_o` one cycle later with `tx_data_o` = 0xA5, and return to IDLE with `grant_o` = 0 after done.
- **Fairness**: all four requesters continuously valid with last=1 bytes. Expect grant order 0,1,2,3,0,1; no requester starves.
- **Lock**: req 1 sends 3 bytes (last on the 3rd) while req 0 stays valid. Expect 3 consecutive req 1 frames, then req 2, then req 0, per the RR pointer.
- **Gap**: `gap_i` = 10, two bytes from req 3. Expect exactly 10 idle cycles between `tx_done_i` rising and the second `req_ready_o`.
- **Enable/reset**: drop `enable_i` in BUSY. Expect the frame to complete and no new grant while the lock is kept. Re-enable, then assert `rst_n_i` low mid-BUSY. Expect all outputs 0 immediately and requester 0 to win first after release.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types for the UART transmit scheduler: FSM state encoding.
package uart_tx_sched_pkg;

   typedef enum logic [1:0] {
      SCHED_IDLE  = 2'd0,
      SCHED_ISSUE = 2'd1,
      SCHED_BUSY  = 2'd2,
      SCHED_GAP   = 2'd3
   } sched_state_t;

   localparam logic [1:0] ST_IDLE  = SCHED_IDLE;
   localparam logic [1:0] ST_ISSUE = SCHED_ISSUE;
   localparam logic [1:0] ST_BUSY  = SCHED_BUSY;
   localparam logic [1:0] ST_GAP   = SCHED_GAP;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester handshakes plus the uart_tx control/data pair driven by the scheduler.
interface uart_tx_sched_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid_i;
   logic [N_REQ*8-1:0] req_data_i;
   logic [N_REQ-1:0]   req_last_i;
   logic [N_REQ-1:0]   req_ready_o;
   logic [N_REQ-1:0]   grant_o;
   logic               tx_init_o;
   logic [7:0]         tx_data_o;
   logic               tx_done_i;

   modport slave (
      input  req_valid_i, req_data_i, req_last_i, tx_done_i,
      output req_ready_o, grant_o, tx_init_o, tx_data_o
   );

   modport master (
      output req_valid_i, req_data_i, req_last_i, tx_done_i,
      input  req_ready_o, grant_o, tx_init_o, tx_data_o
   );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first request strictly after ptr_i, wrapping around.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o
);
   logic [PTR_W:0]   shamt_s;
   logic [2*N-1:0]   dbl_req_s;
   logic [2*N-1:0]   dbl_gnt_s;
   logic [N-1:0]     rot_req_s;
   logic [N-1:0]     rot_gnt_s;

   // Rotate so the requester after ptr_i sits at bit 0, take the lowest set bit, rotate back.
   assign shamt_s   = {1'b0, ptr_i} + {{PTR_W{1'b0}}, 1'b1};
   assign dbl_req_s = {req_i, req_i} >> shamt_s;
   assign rot_req_s = dbl_req_s[N-1:0];
   assign rot_gnt_s = rot_req_s & (~rot_req_s + {{(N-1){1'b0}}, 1'b1});
   assign dbl_gnt_s = {{N{1'b0}}, rot_gnt_s} << shamt_s;
   assign gnt_o     = dbl_gnt_s[N-1:0] | dbl_gnt_s[2*N-1:N];
endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx serializer between N_REQ byte sources.
// Locks to a requester until its last byte and can insert an idle gap after each byte.
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int GAP_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             enable_i,
   input  logic [GAP_W-1:0] gap_i,
   output logic             busy_o,
   uart_tx_sched_if.slave   bus
);
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [1:0]       state_r;
   logic             lock_r;
   logic [PTR_W-1:0] owner_r;
   logic [PTR_W-1:0] ptr_r;
   logic [7:0]       data_r;
   logic [GAP_W-1:0] gap_cnt_r;
   logic             tx_init_r;

   logic [N_REQ-1:0] owner_oh_s;
   logic [N_REQ-1:0] elig_s;
   logic [N_REQ-1:0] win_oh_s;
   logic [PTR_W-1:0] win_idx_s;
   logic [7:0]       win_data_s;
   logic             win_last_s;
   logic             accept_s;
   logic             active_s;

   // One-hot form of the current owner.
   always_comb begin
      owner_oh_s          = '0;
      owner_oh_s[owner_r] = 1'b1;
   end

   assign elig_s = lock_r ? (owner_oh_s & bus.req_valid_i) : bus.req_valid_i;

   rr_arbiter #(
      .N     (N_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req_i (elig_s),
      .ptr_i (ptr_r),
      .gnt_o (win_oh_s)
   );

   // Encode the one-hot winner into an index.
   always_comb begin
      win_idx_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         win_idx_s = win_idx_s | ({PTR_W{win_oh_s[i]}} & PTR_W'(i));
      end
   end

   assign win_data_s = bus.req_data_i[{win_idx_s, 3'b000} +: 8];
   assign win_last_s = bus.req_last_i[win_idx_s];
   // Ready is gated by reset so every output reads 0 while rst_n_i is low.
   assign accept_s   = rst_n_i && (state_r == ST_IDLE) && enable_i && bus.tx_done_i && (|elig_s);
   assign active_s   = lock_r || (state_r != ST_IDLE);

   // Scheduler FSM, lock/owner tracking, RR pointer, data hold and gap counter.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r   <= ST_IDLE;
         lock_r    <= 1'b0;
         owner_r   <= '0;
         ptr_r     <= PTR_W'(N_REQ - 1);
         data_r    <= 8'h00;
         gap_cnt_r <= '0;
         tx_init_r <= 1'b0;
      end else begin
         tx_init_r <= accept_s;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  data_r  <= win_data_s;
                  lock_r  <= !win_last_s;
                  owner_r <= win_idx_s;
                  ptr_r   <= win_idx_s;
                  state_r <= ST_ISSUE;
               end
            end
            ST_ISSUE: state_r <= ST_BUSY;
            ST_BUSY: begin
               if (bus.tx_done_i) begin
                  if (gap_i == '0) begin
                     state_r <= ST_IDLE;
                  end else begin
                     state_r   <= ST_GAP;
                     gap_cnt_r <= gap_i;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt_r <= GAP_W'(1)) begin
                  state_r <= ST_IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r - GAP_W'(1);
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready_o = accept_s ? win_oh_s : '0;
   assign bus.grant_o     = active_s ? owner_oh_s : '0;
   assign bus.tx_init_o   = tx_init_r;
   assign bus.tx_data_o   = data_r;
   assign busy_o          = active_s;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized scoreboard bench for uart_tx_sched with a frame-level scheduling model
// and a simple behavioural uart_tx stand-in that drops done for a random frame time.
module tb_uart_tx_sched;
   localparam int N  = 4;
   localparam int GW = 16;

   typedef struct {
      int         id;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic [GW-1:0] gap = '0;
   logic          busy;

   uart_tx_sched_if #(.N_REQ(N)) bus ();

   uart_tx_sched #(.N_REQ(N), .GAP_W(GW)) dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .enable_i (enable),
      .gap_i    (gap),
      .busy_o   (busy),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // per-requester pending bytes {last, data}
   logic [8:0]       rq [N][$];
   exp_t             sb[$];
   int               order_q[$];
   logic [N-1:0]     vld = '0;
   logic [N*8-1:0]   dat = '0;
   logic [N-1:0]     lst = '0;
   int               hold_pct = 0;
   bit               rand_en = 1'b0;
   bit               rand_gap = 1'b0;

   // reference model state (frame level)
   bit pending = 1'b0;
   int acc_cyc = 0;
   int free_at = 0;
   int done_cyc = 0;
   int idle_gap = 0;
   bit m_lock = 1'b0;
   int m_owner = 0;
   int m_last = N - 1;
   // serializer stand-in
   bit ser_done = 1'b1;
   int ser_cnt = 0;
   bit init_seen = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit queues_empty();
      for (int k = 0; k < N; k++) if (rq[k].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit model_quiet();
      return queues_empty() && !pending && (sb.size() == 0) && (cyc >= free_at);
   endfunction

   task automatic model_reset();
      pending = 1'b0; free_at = 0; m_lock = 1'b0; m_owner = 0; m_last = N - 1;
      sb.delete(); ser_done = 1'b1; ser_cnt = 0; init_seen = 1'b0;
   endtask

   // Drive requesters and the serializer stand-in just after the active edge.
   task automatic drive();
      if (init_seen) begin
         ser_done = 1'b0;
         ser_cnt  = $urandom_range(8, 2);
      end else if (!ser_done) begin
         ser_cnt--;
         if (ser_cnt <= 0) ser_done = 1'b1;
      end
      bus.tx_done_i = ser_done;
      for (int k = 0; k < N; k++) begin
         vld[k] = (rq[k].size() > 0) && !($urandom_range(99, 0) < hold_pct);
         if (rq[k].size() > 0) begin
            dat[8*k +: 8] = rq[k][0][7:0];
            lst[k]        = rq[k][0][8];
         end else begin
            dat[8*k +: 8] = 8'($urandom_range(255, 0));
            lst[k]        = 1'($urandom_range(1, 0));
         end
      end
      bus.req_valid_i = vld;
      bus.req_data_i  = dat;
      bus.req_last_i  = lst;
      if (rand_en) enable = ($urandom_range(9, 0) != 0);
      if (rand_gap && ($urandom_range(19, 0) == 0)) gap = GW'($urandom_range(3, 0));
   endtask

   // Frame-level reference: who may be accepted this cycle and what the scheduler shows.
   task automatic model();
      logic [N-1:0] elig;
      logic [N-1:0] exp_rdy;
      logic [N-1:0] exp_gnt;
      logic [8:0]   b;
      bit           idle;
      int           w;
      idle    = !pending && (cyc >= free_at);
      exp_gnt = (m_lock || !idle) ? (N'(1) << m_owner) : '0;
      chk("grant", bus.grant_o, exp_gnt);
      chk("busy", busy, m_lock || !idle);
      if (pending && (cyc >= acc_cyc + 2) && ser_done) begin
         pending  = 1'b0;
         free_at  = cyc + 1 + int'(gap);
         done_cyc = cyc;
      end
      exp_rdy = '0;
      if (idle && enable && ser_done) begin
         elig = m_lock ? (vld & (N'(1) << m_owner)) : vld;
         w = -1;
         for (int i = 1; i <= N; i++) begin
            if ((w < 0) && elig[(m_last + i) % N]) w = (m_last + i) % N;
         end
         if (w >= 0) begin
            exp_rdy[w] = 1'b1;
            b = rq[w].pop_front();
            sb.push_back('{w, b[7:0], cyc + 1});
            order_q.push_back(w);
            idle_gap = cyc - done_cyc - 1;
            m_last = w; m_owner = w; m_lock = !b[8];
            pending = 1'b1; acc_cyc = cyc;
         end
      end
      chk("req_ready", bus.req_ready_o, exp_rdy);
      init_seen = bus.tx_init_o;
   endtask

   task automatic cycle();
      @(negedge clk);
      model();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_quiet(input string nm, input int budget);
      int n = 0;
      while (!model_quiet() && (n < budget)) begin
         cycle();
         n++;
      end
      if (n >= budget) chk({nm, "_timeout"}, 32'(n), 32'(budget - 1));
   endtask

   task automatic run_until_busy(input string nm, input int budget);
      int n = 0;
      while (!(pending && (cyc >= acc_cyc + 2) && !ser_done) && (n < budget)) begin
         cycle();
         n++;
      end
      if (n >= budget) chk({nm, "_timeout"}, 32'(n), 32'(budget - 1));
   endtask

   task automatic push_burst(input int k, input int len);
      for (int i = 0; i < len; i++) begin
         rq[k].push_back({(i == len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(255, 0))});
      end
   endtask

   task automatic chk_outputs_zero(input string nm);
      chk({nm, "_ready"}, bus.req_ready_o, 32'h0);
      chk({nm, "_grant"}, bus.grant_o, 32'h0);
      chk({nm, "_init"},  bus.tx_init_o, 32'h0);
      chk({nm, "_data"},  bus.tx_data_o, 32'h0);
      chk({nm, "_busy"},  busy, 32'h0);
   endtask

   // Monitor: every start pulse must match the oldest accepted byte; data holds otherwise.
   logic [7:0] held_data = 8'h00;
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
         held_data = 8'h00;
      end else if (bus.tx_init_o) begin
         if (sb.size() == 0) begin
            chk("tx_init_unexpected", 32'h1, 32'h0);
         end else begin
            e = sb.pop_front();
            chk("init_cycle", 32'(cyc), 32'(e.cyc));
            chk("tx_data", bus.tx_data_o, e.data);
            chk("init_grant", bus.grant_o, 32'h1 << e.id);
            held_data = e.data;
         end
      end else begin
         chk("data_hold", bus.tx_data_o, held_data);
      end
   end

   int fair_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int lock_exp[5] = '{1, 1, 1, 2, 0};

   initial begin
      bus.req_valid_i = '1;
      bus.req_data_i  = '1;
      bus.req_last_i  = '0;
      bus.tx_done_i   = 1'b1;
      enable = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      model_reset();
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive();

      // fairness: all four valid with single-byte bursts
      order_q.delete();
      for (int k = 0; k < N; k++) begin
         push_burst(k, 1);
         push_burst(k, 1);
      end
      run_quiet("fair", 400);
      chk("fair_count", 32'(order_q.size()), 32'd8);
      if (order_q.size() == 8) begin
         for (int i = 0; i < 8; i++) chk("fair_order", 32'(order_q[i]), 32'(fair_exp[i]));
      end

      // single byte from requester 2
      order_q.delete();
      rq[2].push_back({1'b1, 8'hA5});
      run_quiet("single", 100);
      chk("single_winner", 32'(order_q.size() == 1 ? order_q[0] : -1), 32'd2);
      chk("single_grant_idle", bus.grant_o, 32'h0);

      // lock: 3-byte burst from requester 1, others join after it starts
      order_q.delete();
      push_burst(1, 3);
      begin
         int n = 0;
         while ((order_q.size() == 0) && (n < 50)) begin
            cycle();
            n++;
         end
      end
      push_burst(0, 1);
      push_burst(2, 1);
      run_quiet("lock", 300);
      chk("lock_count", 32'(order_q.size()), 32'd5);
      if (order_q.size() == 5) begin
         for (int i = 0; i < 5; i++) chk("lock_order", 32'(order_q[i]), 32'(lock_exp[i]));
      end

      // gap of 10 between two bytes of requester 3
      gap = GW'(10);
      push_burst(3, 2);
      run_quiet("gap", 300);
      chk("gap_idle_cycles", 32'(idle_gap), 32'd10);
      gap = '0;

      // randomized traffic with stalls, enable drops and varying gaps
      for (int i = 0; i < 40; i++) push_burst($urandom_range(N - 1, 0), $urandom_range(3, 1));
      hold_pct = 30; rand_en = 1'b1; rand_gap = 1'b1;
      run_quiet("random", 20000);
      hold_pct = 0; rand_en = 1'b0; rand_gap = 1'b0;
      enable = 1'b1; gap = '0;
      run_quiet("drain", 200);

      // enable drop in BUSY keeps the lock, then reset mid-BUSY
      order_q.delete();
      push_burst(1, 3);
      run_until_busy("en_busy", 100);
      enable = 1'b0;
      repeat (30) cycle();
      chk("en_low_accepts", 32'(order_q.size()), 32'd1);
      chk("en_low_lock_grant", bus.grant_o, 32'h2);
      enable = 1'b1;
      run_until_busy("en_resume", 100);
      chk("en_resume_accepts", 32'(order_q.size()), 32'd2);
      rst_n = 1'b0;
      model_reset();
      bus.tx_done_i = 1'b1;
      push_burst(0, 1);
      #1;
      chk_outputs_zero("mid_reset");
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      order_q.delete();
      drive();
      run_quiet("post_reset", 200);
      chk("post_reset_first", 32'(order_q.size() > 0 ? order_q[0] : -1), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
